cp0_param: RTL and testbench

Parametrised coprocessor-0 for the pipelined CPU: holds STATUS, CAUSE, EPC, BADVADDR, COUNT and COMPARE, arbitrates exceptions, ERET and interrupts presented by the WB stage, and redirects fetch. It extends the single-timer CP0 with a configurable number of synchronised external interrupt lines, a programmable timer prescaler, a parametrised exception entry address and precise interrupt entry recorded in EPC/ExcCode. It sits beside WB; MFC0 reads and MTC0 writes arrive from WB.

---
 rtl/cp0_param.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_cp0_param.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_param.sv
// -----------------------------------------------------------------------------
// cp0_param -- parametrised coprocessor 0 for the pipelined CPU.
//
// Holds STATUS, CAUSE, EPC, BADVADDR and, when the timer is built in, COUNT and
// COMPARE. Arbitrates exceptions, interrupts and ERET presented by the WB stage
// and produces the fetch redirect. External interrupt lines are synchronised
// before they reach CAUSE.IP[6:2].
//
// Optional feature macro: CP0_TIMER_EN
//   defined   : COUNT, COMPARE, prescaler and timer interrupt (TI) present.
//   undefined : no timer logic; COUNT/COMPARE read 0, writes ignored, TI = 0.
//
// Parameters
//   HW_INT_NUM      external interrupt lines (1..5), CAUSE.IP[2+HW_INT_NUM-1:2]
//   INT_SYNC_STAGES synchroniser depth on hw_int (1..3)
//   TIMER_DIV       core cycles per COUNT increment (1..256)
//   EXC_BASE        exception / interrupt entry address
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   mtc0, cp0r_addr, wdata      register write from WB ({reg[4:0], sel[2:0]})
//   eret                        ERET in WB
//   wb_valid, wb_over           WB holds a valid instruction / completes now
//   ex_valid_i, ex_code_i,
//   ex_bd_i, ex_pc_i            exception raised by the WB instruction
//   badvaddr_valid_i/badvaddr_i faulting address
//   hw_int                      asynchronous level interrupt requests
//   cp0r_rdata                  MFC0 read data (combinational)
//   cancel, exc_valid, exc_pc   pipeline flush and fetch redirect
//   cp0r_status/cause/epc       register values
//   c0_int                      interrupt pending and enabled
// -----------------------------------------------------------------------------
module cp0_param #(
   parameter int          HW_INT_NUM      = 5,
   parameter int          INT_SYNC_STAGES = 2,
   parameter int          TIMER_DIV       = 2,
   parameter logic [31:0] EXC_BASE        = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  mtc0,
   input  logic [7:0]            cp0r_addr,
   input  logic [31:0]           wdata,
   input  logic                  eret,
   input  logic                  wb_valid,
   input  logic                  wb_over,
   input  logic                  ex_valid_i,
   input  logic [4:0]            ex_code_i,
   input  logic                  ex_bd_i,
   input  logic [31:0]           ex_pc_i,
   input  logic                  badvaddr_valid_i,
   input  logic [31:0]           badvaddr_i,
   input  logic [HW_INT_NUM-1:0] hw_int,
   output logic [31:0]           cp0r_rdata,
   output logic                  cancel,
   output logic                  exc_valid,
   output logic [31:0]           exc_pc,
   output logic [31:0]           cp0r_status,
   output logic [31:0]           cp0r_cause,
   output logic [31:0]           cp0r_epc,
   output logic                  c0_int
);

   // {reg, sel}; only sel = 0 is decoded
   localparam logic [7:0]  ADDR_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0]  ADDR_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0]  ADDR_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0]  ADDR_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0]  ADDR_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0]  ADDR_EPC      = {5'd14, 3'd0};

   localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [31:0]           status_q,   status_d;
   logic                  bd_q,       bd_d;
   logic [1:0]            ip_sw_q,    ip_sw_d;
   logic [4:0]            exc_code_q, exc_code_d;
   logic [31:0]           epc_q,      epc_d;
   logic [31:0]           badvaddr_q, badvaddr_d;
   logic [HW_INT_NUM-1:0] sync_q [INT_SYNC_STAGES];
   logic [HW_INT_NUM-1:0] sync_d [INT_SYNC_STAGES];

   // Timer view seen by the rest of the block (constant 0 without the timer)
   logic                  ti;
   logic [31:0]           count_rd;
   logic [31:0]           compare_rd;

   logic [4:0]            ip_hw;
   logic [7:0]            ip;
   logic [31:0]           cause;

   logic                  take_exc;
   logic                  take_int;
   logic                  take_eret;
   logic                  do_mtc0;
   logic                  wr_status;
   logic                  wr_cause;
   logic                  wr_epc;

   // ---------------------------------------------------------------------------
   // CAUSE assembly and interrupt request
   // ---------------------------------------------------------------------------
   // NOTE: every signal written in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      ip_hw                   = '0;
      ip_hw[HW_INT_NUM-1:0]   = sync_q[INT_SYNC_STAGES-1];
   end

   assign ip     = {ti, ip_hw, ip_sw_q};
   assign cause  = {bd_q, ti, 14'd0, ip, 1'b0, exc_code_q, 2'b00};
   assign c0_int = (|(ip & status_q[15:8])) & status_q[0] & ~status_q[1];

   // ---------------------------------------------------------------------------
   // WB-cycle arbitration: exception > interrupt > ERET > MTC0
   // ---------------------------------------------------------------------------
   always_comb begin
      take_exc  = wb_valid & ex_valid_i;
      take_int  = wb_valid & ~ex_valid_i & c0_int;
      take_eret = wb_valid & ~ex_valid_i & ~c0_int & eret;
      do_mtc0   = wb_valid & ~ex_valid_i & ~c0_int & ~eret & mtc0;
      wr_status = do_mtc0 & (cp0r_addr == ADDR_STATUS);
      wr_cause  = do_mtc0 & (cp0r_addr == ADDR_CAUSE);
      wr_epc    = do_mtc0 & (cp0r_addr == ADDR_EPC);
   end

   // Redirect is purely combinational from inputs and current registers; an
   // interrupt also redirects, so it is part of the flush term.
   assign exc_valid = (ex_valid_i | c0_int | eret) & wb_valid;
   assign cancel    = exc_valid & wb_over;
   assign exc_pc    = (eret & ~ex_valid_i & ~c0_int) ? epc_q : EXC_BASE;

   // ---------------------------------------------------------------------------
   // Next-state for STATUS, CAUSE software/exception fields, EPC, BADVADDR
   // ---------------------------------------------------------------------------
   always_comb begin
      status_d   = status_q;
      bd_d       = bd_q;
      ip_sw_d    = ip_sw_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;

      if (wr_status) begin
         status_d = wdata & STATUS_WMASK;
      end
      if (wr_cause) begin
         ip_sw_d = wdata[9:8];
      end
      if (wr_epc) begin
         epc_d = wdata;
      end

      if (take_exc) begin
         status_d[1] = 1'b1;
         bd_d        = ex_bd_i;
         exc_code_d  = ex_code_i;
         epc_d       = ex_pc_i;
         if (badvaddr_valid_i) begin
            badvaddr_d = badvaddr_i;
         end
      end else if (take_int) begin
         // Interrupt is taken precisely on the WB instruction, which is not
         // committed; EPC points back at it (or its branch when in a slot).
         status_d[1] = 1'b1;
         bd_d        = ex_bd_i;
         exc_code_d  = 5'd0;
         epc_d       = ex_pc_i;
      end else if (take_eret) begin
         status_d[1] = 1'b0;
      end
   end

   // Synchroniser shift: stage 0 samples the asynchronous lines
   always_comb begin
      sync_d[0] = hw_int;
      for (int i = 1; i < INT_SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         status_q   <= '0;
         bd_q       <= 1'b0;
         ip_sw_q    <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
         // NOTE: the synchroniser stages are reset too, so a reset discards
         // interrupt levels already in flight instead of replaying them.
         for (int i = 0; i < INT_SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         status_q   <= status_d;
         bd_q       <= bd_d;
         ip_sw_q    <= ip_sw_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         sync_q     <= sync_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Timer: prescaler, COUNT, COMPARE, TI
   // ---------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
   localparam int            PW         = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

   logic [PW-1:0] presc_q,   presc_d;
   logic [31:0]   count_q,   count_d;
   logic [31:0]   compare_q, compare_d;
   logic          ti_q,      ti_d;
   logic [31:0]   count_inc;
   logic          tick;
   logic          wr_count;
   logic          wr_compare;

   always_comb begin
      wr_count   = do_mtc0 & (cp0r_addr == ADDR_COUNT);
      wr_compare = do_mtc0 & (cp0r_addr == ADDR_COMPARE);
      tick       = (presc_q == PRESC_LAST);
      count_inc  = count_q + 32'd1;

      presc_d    = tick ? '0 : presc_q + 1'b1;
      count_d    = tick ? count_inc : count_q;
      compare_d  = compare_q;
      ti_d       = ti_q;

      // TI fires on the tick that lands COUNT on COMPARE
      if (tick && !wr_count && (count_inc == compare_q)) begin
         ti_d = 1'b1;
      end
      // A COUNT write restarts the prescaler so the next tick is a full period away
      if (wr_count) begin
         count_d = wdata;
         presc_d = '0;
      end
      // Writing COMPARE acknowledges the timer; the clear beats a same-cycle set
      if (wr_compare) begin
         compare_d = wdata;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign ti         = ti_q;
   assign count_rd   = count_q;
   assign compare_rd = compare_q;
`else
   assign ti         = 1'b0;
   assign count_rd   = '0;
   assign compare_rd = '0;
`endif

   // ---------------------------------------------------------------------------
   // Read port and register outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      cp0r_rdata = '0;
      case (cp0r_addr)
         ADDR_BADVADDR: cp0r_rdata = badvaddr_q;
         ADDR_COUNT:    cp0r_rdata = count_rd;
         ADDR_COMPARE:  cp0r_rdata = compare_rd;
         ADDR_STATUS:   cp0r_rdata = status_q;
         ADDR_CAUSE:    cp0r_rdata = cause;
         ADDR_EPC:      cp0r_rdata = epc_q;
         default:       cp0r_rdata = '0;
      endcase
   end

   assign cp0r_status = status_q;
   assign cp0r_cause  = cause;
   assign cp0r_epc    = epc_q;

endmodule

// File: tb/tb_cp0_param.sv
// -----------------------------------------------------------------------------
// tb_cp0_param -- self-checking bench for cp0_param.
// A behavioural model tracks CP0 state from the architectural rules (COUNT as
// load value plus elapsed cycles / TIMER_DIV, interrupt lines as a delayed
// history) and a negedge process compares every output against it. Directed
// steps add hand-computed literal expectations. Timer expectations follow
// CP0_TIMER_EN.
// -----------------------------------------------------------------------------
module tb_cp0_param;

   localparam int          HWN   = 5;
   localparam int          SYNC  = 2;
   localparam int          DIV   = 2;
   localparam logic [31:0] EBASE = 32'h8000_0180;
`ifdef CP0_TIMER_EN
   localparam bit          TEN   = 1'b1;
`else
   localparam bit          TEN   = 1'b0;
`endif

   localparam logic [7:0] A_BAD     = 8'h40;
   localparam logic [7:0] A_COUNT   = 8'h48;
   localparam logic [7:0] A_COMPARE = 8'h58;
   localparam logic [7:0] A_STATUS  = 8'h60;
   localparam logic [7:0] A_CAUSE   = 8'h68;
   localparam logic [7:0] A_EPC     = 8'h70;

   logic           clk = 1'b0;
   logic           resetn;
   logic           mtc0;
   logic [7:0]     cp0r_addr;
   logic [31:0]    wdata;
   logic           eret;
   logic           wb_valid;
   logic           wb_over;
   logic           ex_valid_i;
   logic [4:0]     ex_code_i;
   logic           ex_bd_i;
   logic [31:0]    ex_pc_i;
   logic           badvaddr_valid_i;
   logic [31:0]    badvaddr_i;
   logic [HWN-1:0] hw_int;
   logic [31:0]    cp0r_rdata;
   logic           cancel;
   logic           exc_valid;
   logic [31:0]    exc_pc;
   logic [31:0]    cp0r_status;
   logic [31:0]    cp0r_cause;
   logic [31:0]    cp0r_epc;
   logic           c0_int;

   int n_checks = 0;
   int n_errors = 0;

   cp0_param #(
      .HW_INT_NUM      (HWN),
      .INT_SYNC_STAGES (SYNC),
      .TIMER_DIV       (DIV),
      .EXC_BASE        (EBASE)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .mtc0             (mtc0),
      .cp0r_addr        (cp0r_addr),
      .wdata            (wdata),
      .eret             (eret),
      .wb_valid         (wb_valid),
      .wb_over          (wb_over),
      .ex_valid_i       (ex_valid_i),
      .ex_code_i        (ex_code_i),
      .ex_bd_i          (ex_bd_i),
      .ex_pc_i          (ex_pc_i),
      .badvaddr_valid_i (badvaddr_valid_i),
      .badvaddr_i       (badvaddr_i),
      .hw_int           (hw_int),
      .cp0r_rdata       (cp0r_rdata),
      .cancel           (cancel),
      .exc_valid        (exc_valid),
      .exc_pc           (exc_pc),
      .cp0r_status      (cp0r_status),
      .cp0r_cause       (cp0r_cause),
      .cp0r_epc         (cp0r_epc),
      .c0_int           (c0_int)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   bit          m_ie, m_exl, m_bd, m_ti;
   logic [7:0]  m_im;
   logic [1:0]  m_sw;
   logic [4:0]  m_code;
   logic [31:0] m_epc, m_bad, m_load, m_compare;
   int          m_elapsed;
   logic [4:0]  m_hq[$];          // m_hq[0] newest sample of hw_int
   bit          started = 1'b0;

   function automatic logic [31:0] m_count();
      return TEN ? m_load + 32'(m_elapsed / DIV) : 32'd0;
   endfunction

   function automatic logic [7:0] m_ip();
      return {m_ti, m_hq[SYNC-1], m_sw};
   endfunction

   function automatic bit m_int();
      return (|(m_ip() & m_im)) && m_ie && !m_exl;
   endfunction

   function automatic logic [31:0] m_status_w();
      return {16'h0, m_im, 6'h0, m_exl, m_ie};
   endfunction

   function automatic logic [31:0] m_cause_w();
      return {m_bd, m_ti, 14'h0, m_ip(), 1'b0, m_code, 2'b00};
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a)
         A_BAD:     return m_bad;
         A_COUNT:   return m_count();
         A_COMPARE: return TEN ? m_compare : 32'd0;
         A_STATUS:  return m_status_w();
         A_CAUSE:   return m_cause_w();
         A_EPC:     return m_epc;
         default:   return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      bit          irq;
      bit          wr;
      logic [31:0] old_compare;
      if (!resetn) begin
         m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0;
         m_im = '0; m_sw = '0; m_code = '0;
         m_epc = '0; m_bad = '0; m_load = '0; m_compare = '0;
         m_elapsed = 0;
         m_hq.delete();
         for (int i = 0; i < SYNC; i++) m_hq.push_back(5'd0);
      end else begin
         irq         = m_int();
         old_compare = m_compare;
         wr          = wb_valid && mtc0 && !ex_valid_i && !irq && !eret;
         if (TEN) begin
            if (wr && cp0r_addr == A_COUNT) begin
               m_load    = wdata;
               m_elapsed = 0;
            end else begin
               m_elapsed++;
               if ((m_elapsed % DIV) == 0 && m_count() == old_compare) m_ti = 1;
            end
            if (wr && cp0r_addr == A_COMPARE) begin
               m_compare = wdata;
               m_ti      = 0;
            end
         end
         if (wb_valid && ex_valid_i) begin
            m_exl = 1; m_bd = ex_bd_i; m_code = ex_code_i; m_epc = ex_pc_i;
            if (badvaddr_valid_i) m_bad = badvaddr_i;
         end else if (wb_valid && irq) begin
            m_exl = 1; m_bd = ex_bd_i; m_code = 5'd0; m_epc = ex_pc_i;
         end else if (wb_valid && eret) begin
            m_exl = 0;
         end else if (wr) begin
            case (cp0r_addr)
               A_STATUS: begin m_ie = wdata[0]; m_exl = wdata[1]; m_im = wdata[15:8]; end
               A_CAUSE:  m_sw  = wdata[9:8];
               A_EPC:    m_epc = wdata;
               default:  ;
            endcase
         end
         m_hq.push_front(hw_int);
         m_hq.delete(SYNC);
      end
      started = 1'b1;
   endtask

   always @(posedge clk) model_step();

   // Single compare process, mid-cycle
   always @(negedge clk) begin
      if (started) begin
         check("status",    cp0r_status,     m_status_w());
         check("cause",     cp0r_cause,      m_cause_w());
         check("epc",       cp0r_epc,        m_epc);
         check("rdata",     cp0r_rdata,      m_read(cp0r_addr));
         check("c0_int",    32'(c0_int),     32'(m_int()));
         check("exc_valid", 32'(exc_valid),  32'(wb_valid && (ex_valid_i || m_int() || eret)));
         check("cancel",    32'(cancel),     32'(wb_valid && wb_over && (ex_valid_i || m_int() || eret)));
         check("exc_pc",    exc_pc,          (eret && !ex_valid_i && !m_int()) ? m_epc : EBASE);
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_in();
      mtc0 = 0; wdata = '0; eret = 0; wb_valid = 0; wb_over = 0;
      ex_valid_i = 0; ex_code_i = '0; ex_bd_i = 0; ex_pc_i = '0;
      badvaddr_valid_i = 0; badvaddr_i = '0;
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
      wb_valid = 1; mtc0 = 1; cp0r_addr = a; wdata = d;
      step();
      clear_in();
   endtask

   task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
      cp0r_addr = a;
      #1;
      check(name, cp0r_rdata, exp);
   endtask

   initial begin
      resetn = 0; hw_int = '0; cp0r_addr = '0;
      clear_in();
      repeat (3) step();

      // Reset state
      check("rst_status", cp0r_status, 32'h0);
      check("rst_cause",  cp0r_cause,  32'h0);
      check("rst_epc",    cp0r_epc,    32'h0);
      check("rst_exc_pc", exc_pc,      EBASE);
      check("rst_c0_int", 32'(c0_int), 32'h0);

      // Timer: COMPARE=5 written on edge 1; COUNT=4 after edge 9, 5 after edge 10
      resetn = 1;
      write_reg(A_COMPARE, 32'd5);
      repeat (8) step();
      read_chk("count_9", A_COUNT, TEN ? 32'd4 : 32'd0);
      check("ti_9", 32'(cp0r_cause[30]), 32'h0);
      step();
      read_chk("count_10", A_COUNT, TEN ? 32'd5 : 32'd0);
      check("ti_10",  32'(cp0r_cause[30]), 32'(TEN));
      check("ip7_10", 32'(cp0r_cause[15]), 32'(TEN));
      write_reg(A_COMPARE, 32'd8);
      check("ti_clr", 32'(cp0r_cause[30]), 32'h0);

      // External interrupt through the synchroniser
      write_reg(A_STATUS, 32'h0000_0401);
      check("status_wr", cp0r_status, 32'h0000_0401);
      hw_int = 5'b00001;
      step();
      check("int_edge1", 32'(c0_int), 32'h0);
      step();
      check("int_edge2", 32'(c0_int), 32'h1);
      check("ip2", 32'(cp0r_cause[10]), 32'h1);
      wb_valid = 1; wb_over = 1; ex_pc_i = 32'h100;
      mtc0 = 1; cp0r_addr = A_EPC; wdata = 32'h555;
      #1;
      check("int_exc_valid", 32'(exc_valid), 32'h1);
      check("int_cancel",    32'(cancel),    32'h1);
      check("int_exc_pc",    exc_pc,         EBASE);
      step();
      clear_in(); hw_int = '0;
      check("int_epc",    cp0r_epc,         32'h100);
      check("int_code",   32'(cp0r_cause[6:2]), 32'h0);
      check("int_status", cp0r_status,      32'h0000_0403);
      check("int_masked", 32'(c0_int),      32'h0);

      // ERET alone
      write_reg(A_EPC, 32'h300);
      step(); step();
      wb_valid = 1; wb_over = 1; eret = 1;
      #1;
      check("eret_exc_pc", exc_pc,         32'h300);
      check("eret_cancel", 32'(cancel),    32'h1);
      check("eret_valid",  32'(exc_valid), 32'h1);
      step();
      clear_in();
      check("eret_exl", 32'(cp0r_status[1]), 32'h0);

      // Exception beats same-cycle ERET and MTC0 STATUS
      wb_valid = 1; wb_over = 1; ex_valid_i = 1; ex_code_i = 5'd8; ex_bd_i = 1;
      ex_pc_i = 32'h200; eret = 1; mtc0 = 1; cp0r_addr = A_STATUS; wdata = 32'hFFFF_FFFF;
      badvaddr_valid_i = 1; badvaddr_i = 32'hDEAD_BEEF;
      #1;
      check("exc_exc_pc", exc_pc, EBASE);
      step();
      clear_in();
      check("exc_epc",    cp0r_epc,             32'h200);
      check("exc_bd",     32'(cp0r_cause[31]),  32'h1);
      check("exc_code",   32'(cp0r_cause[6:2]), 32'd8);
      check("exc_status", cp0r_status,          32'h0000_0403);
      read_chk("badvaddr", A_BAD, 32'hDEAD_BEEF);
      write_reg(A_BAD, 32'h1234);
      read_chk("badvaddr_ro", A_BAD, 32'hDEAD_BEEF);

      // COUNT wrap
      write_reg(A_COUNT, 32'hFFFF_FFFF);
      read_chk("count_ld", A_COUNT, TEN ? 32'hFFFF_FFFF : 32'd0);
      step();
      read_chk("count_hold", A_COUNT, TEN ? 32'hFFFF_FFFF : 32'd0);
      step();
      read_chk("count_wrap", A_COUNT, 32'd0);

      // CAUSE write mask: only IP[1:0] change
      write_reg(A_CAUSE, 32'hFFFF_FFFF);
      check("cause_sw",   32'(cp0r_cause[9:8]), 32'd3);
      check("cause_bd",   32'(cp0r_cause[31]),  32'h1);
      check("cause_code", 32'(cp0r_cause[6:2]), 32'd8);

      // Undecoded addresses
      read_chk("rd_unmapped", {5'd15, 3'd0}, 32'h0);
      read_chk("rd_sel1",     {5'd12, 3'd1}, 32'h0);

      // Reset mid-operation discards synchronised interrupts and all state
      hw_int = 5'b10000;
      step(); step();
      check("ip6_pre", 32'(cp0r_cause[14]), 32'h1);
      resetn = 0;
      step();
      check("rst2_cause",  cp0r_cause,  32'h0);
      check("rst2_status", cp0r_status, 32'h0);
      check("rst2_epc",    cp0r_epc,    32'h0);
      resetn = 1; hw_int = '0;
      repeat (3) step();
      check("post_cause", cp0r_cause, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
